spynet_flow_streamer: RTL and testbench

- Output-side counterpart of the SPyNet evaluate_network wrapper.
- Takes the 32-bit output_channels words the network emits: two signed BITS-wide flow channels per word, x in [15:0] and y in [31:16].
- Buffers them in a small FIFO and emits them as an AXI4-Stream master towards the PS/DMA, with row (tlast) and frame (tuser) framing.
- The network cannot be stalled, so overflow is detected and flagged, never back-pressured.

---
 rtl/spynet_stream_pkg.sv | 14 +
 rtl/spynet_sync_fifo.sv | 41 ++++
 rtl/spynet_flow_streamer.sv | 99 +++++++++
 tb/tb_spynet_flow_streamer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/spynet_stream_pkg.sv
// spynet_stream_pkg: shared constants, state encoding and channel clamp helper for the flow streamer
package spynet_stream_pkg;
  localparam int CH_BITS = 16;
  localparam int X_LSB = 0;
  localparam int Y_LSB = 16;
  localparam int CNT_W = 12;
  localparam int TAG_W = 2;
  typedef enum logic [1:0] {IDLE, ARMED, DRAIN} state_t;
  function automatic logic [CH_BITS-1:0] clamp_ch(input logic signed [CH_BITS-1:0] v, input logic [CH_BITS-1:0] mag);
    logic signed [CH_BITS-1:0] m;
    m = $signed(mag);
    return v > m ? m : v < -m ? -m : v;
  endfunction
endpackage

// File: rtl/spynet_sync_fifo.sv
// spynet_sync_fifo: first-word-fall-through synchronous FIFO with flush
// Ports: clk, rst_n (async, active low); flush empties the FIFO; push/din write; pop/dout read
// the head; full, empty and count report occupancy.
module spynet_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign dout = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/spynet_flow_streamer.sv
// spynet_flow_streamer: buffers SPyNet flow words and streams them as a framed AXI4-Stream master
// Ports: clk, rst_n (async, active low); start_frame arms or aborts a frame; in_valid/in_data
// carry {y,x} flow words from the network; m_axis_* is the stream (tlast = end of row,
// tuser = first word of frame); frame_done pulses on the final word handshake; overflow is
// sticky per frame; busy marks a frame in progress.
// Build option: define FLOW_CLAMP_EN to saturate each channel to +/-CLAMP_MAG before buffering.
module spynet_flow_streamer
  import spynet_stream_pkg::*;
#(
  parameter int          BITS       = CH_BITS,
  parameter int          ROW_WORDS  = 64,
  parameter int          FRAME_ROWS = 48,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] CLAMP_MAG  = 16'd2047
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_frame,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        frame_done,
  output logic        overflow,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef FLOW_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif
  state_t state, state_nx;
  logic [CNT_W-1:0] col, row;
  logic armed, take, last_col, last_word, pop, push, drop, full, empty;
  logic [AW:0] count;
  logic [TAG_W+31:0] head;
  logic [31:0] wdata, clamped;
  assign clamped = {clamp_ch(in_data[Y_LSB +: BITS], CLAMP_MAG), clamp_ch(in_data[X_LSB +: BITS], CLAMP_MAG)};
  assign wdata = CLAMP_ON ? clamped : in_data;
  assign armed = state == ARMED;
  // start_frame wins over a same-cycle word: the old frame is flushed, the word belongs to nobody
  assign take = armed && in_valid && !start_frame;
  assign last_col = col == CNT_W'(ROW_WORDS - 1);
  assign last_word = last_col && row == CNT_W'(FRAME_ROWS - 1);
  assign pop = !empty && m_axis_tready;
  // a pop in the same cycle frees the slot, so full alone is not a drop
  assign push = take && (!full || pop);
  assign drop = take && full && !pop;
  spynet_sync_fifo #(.WIDTH(TAG_W + 32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(start_frame),
    .push(push),
    .din({row == '0 && col == '0, last_col, wdata}),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // DRAIN always starts non-empty, so the pop that leaves one entry behind is the final word
  always_comb begin
    state_nx = state;
    frame_done = 1'b0;
    if (start_frame) state_nx = ARMED;
    else if (take && last_word) state_nx = DRAIN;
    else if (state == DRAIN && pop && count == (AW+1)'(1)) begin
      state_nx = IDLE;
      frame_done = 1'b1;
    end
  end
  // counters follow every network word, dropped or not, so framing stays aligned
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      overflow <= 1'b0;
    end else if (start_frame) begin
      col <= '0;
      row <= '0;
      overflow <= 1'b0;
    end else if (take) begin
      col <= last_col ? '0 : col + 1'b1;
      row <= last_word ? '0 : last_col ? row + 1'b1 : row;
      overflow <= overflow | drop;
    end
  assign busy = state != IDLE;
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata = empty ? '0 : head[31:0];
  assign m_axis_tlast = !empty && head[32];
  assign m_axis_tuser = !empty && head[33];
endmodule

// File: tb/tb_spynet_flow_streamer.sv
// tb_spynet_flow_streamer: table-driven, scenario and randomized checks of the flow streamer
module tb_spynet_flow_streamer;
  localparam int RW = 4, FR = 2, DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0, start_frame = 1'b0, in_valid = 1'b0, m_axis_tready = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] tdata, tdata1;
  logic tvalid, tlast, tuser, done, ovf, busy;
  logic tvalid1, tlast1, tuser1, done1, ovf1, busy1;
  always #5 clk = ~clk;
  spynet_flow_streamer #(.BITS(16), .ROW_WORDS(RW), .FRAME_ROWS(FR), .FIFO_DEPTH(DEPTH), .CLAMP_MAG(16'd2047)) u0 (
    .clk(clk), .rst_n(rst_n), .start_frame(start_frame), .in_valid(in_valid), .in_data(in_data),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(tlast),
    .m_axis_tuser(tuser), .frame_done(done), .overflow(ovf), .busy(busy));
  spynet_flow_streamer #(.BITS(16), .ROW_WORDS(1), .FRAME_ROWS(3), .FIFO_DEPTH(2), .CLAMP_MAG(16'd2047)) u1 (
    .clk(clk), .rst_n(rst_n), .start_frame(start_frame), .in_valid(in_valid), .in_data(in_data),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(m_axis_tready), .m_axis_tlast(tlast1),
    .m_axis_tuser(tuser1), .frame_done(done1), .overflow(ovf1), .busy(busy1));
  int errors = 0, checks = 0, cyc = 0;
  logic [33:0] q[$];
  int m_st, m_n;
  bit m_ovf;
  typedef struct {bit sf; bit iv; bit tr; logic [31:0] d; logic [5:0] e_flags; logic [31:0] e_data;} vec_t;
  vec_t tbl[7];
  function automatic logic [15:0] sat(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    if (s > 2047) s = 2047;
    if (s < -2047) s = -2047;
    return 16'(s);
  endfunction
  function automatic logic [31:0] shape(input logic [31:0] d);
`ifdef FLOW_CLAMP_EN
    return {sat(d[31:16]), sat(d[15:0])};
`else
    return d;
`endif
  endfunction
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask
  task automatic mreset();
    q.delete();
    m_st = 0;
    m_n = 0;
    m_ovf = 0;
  endtask
  task automatic cycle(input bit sf, input bit iv, input logic [31:0] d, input bit tr);
    bit pop, exp_done;
    logic [33:0] h;
    start_frame = sf;
    in_valid = iv;
    in_data = d;
    m_axis_tready = tr;
    #1;
    h = q.size() > 0 ? q[0] : '0;
    pop = q.size() > 0 && tr;
    exp_done = m_st == 2 && pop && q.size() == 1 && !sf;
    check("stream", {26'd0, tvalid, tuser, tlast, done, ovf, busy, tdata},
          {26'd0, q.size() > 0, h[33], h[32], exp_done, m_ovf, m_st != 0, h[31:0]});
    if (sf) begin
      mreset();
      m_st = 1;
    end else begin
      if (pop) void'(q.pop_front());
      if (m_st == 1 && iv) begin
        if (q.size() < DEPTH) q.push_back({m_n == 0, (m_n % RW) == RW - 1, shape(d)});
        else m_ovf = 1;
        m_n++;
        if (m_n == RW * FR) m_st = 2;
      end
      if (exp_done) m_st = 0;
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 check("async_rst", {26'd0, tvalid, tuser, tlast, done, ovf, busy, tdata}, 64'd0);
    start_frame = 1'b0;
    in_valid = 1'b0;
    m_axis_tready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mreset();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h0, 6'b000000, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h0011_0022, 6'b000001, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0033_0044, 6'b111001, 32'h0011_0022};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h0055_0066, 6'b101001, 32'h0033_0044};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h0, 6'b101101, 32'h0055_0066};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h0077_0088, 6'b000000, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h0, 6'b000000, 32'h0};
    @(negedge clk);
    #1 check("reset", {26'd0, tvalid, tuser, tlast, done, ovf, busy, tdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mreset();
    for (int i = 0; i < 7; i++) begin
      start_frame = tbl[i].sf;
      in_valid = tbl[i].iv;
      in_data = tbl[i].d;
      m_axis_tready = tbl[i].tr;
      #1 check("row1_table", {26'd0, tvalid1, tuser1, tlast1, done1, ovf1, busy1, tdata1},
               {26'd0, tbl[i].e_flags, tbl[i].e_data});
      cyc++;
      @(negedge clk);
    end
    async_reset();
    cycle(1, 0, 0, 1);
    for (int i = 1; i <= 8; i++) cycle(0, 1, 32'h0001_0001 * i, 1);
    repeat (3) cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) cycle(0, 1, 32'h0001_0001 * i, 0);
    repeat (12) cycle(0, 0, 0, 0);
    check("ovf_sticky", {63'd0, ovf}, 64'd1);
    cycle(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(0, 1, 32'h0100_0100 * i, 0);
    for (int i = 5; i <= 8; i++) cycle(0, 1, 32'h0100_0100 * i, 1);
    repeat (6) cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) cycle(0, 1, 32'h0002_0003 * i, 0);
    cycle(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) cycle(0, 1, 32'h0003_0002 * i, 1);
    repeat (4) cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) cycle(0, 1, 32'h0004_0005 * i, 0);
    async_reset();
    repeat (3) cycle(0, 1, 32'h0000_0123, 1);
    repeat (2) cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(0, 1, 32'h8000_7FFF, 0);
`ifdef FLOW_CLAMP_EN
    #1 check("clamp", {32'd0, tdata}, {32'd0, 32'hF801_07FF});
`else
    #1 check("clamp", {32'd0, tdata}, {32'd0, 32'h8000_7FFF});
`endif
    cycle(0, 0, 0, 1);
    repeat (600) cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
